led_frame_sequencer: RTL and testbench

Control FSM for the LED-strip transmit path. It walks the LED index through all LEDs and strobes the 24-bit shift register to load and shift. It paces each bit to the strip's bit period, then holds the line in the latch (reset) gap before declaring the frame complete. It replaces free-running frame counting: it drives the frame mux select and the shift register controls, and owns the latch timing.

---
 rtl/led_frame_sequencer.sv | 169 ++++++++++++++++
 tb/tb_led_frame_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_sequencer.sv
// Frame sequencer for the LED-strip transmit path: walks the LED index, paces each bit,
// and strobes load/shift for the 24-bit shift register. Ends every frame with the latch gap.
module led_frame_sequencer #(
  parameter int N_LEDS       = 8,
  parameter int BITS_PER_LED = 24,
  parameter int BIT_CLKS     = 63,
  parameter int RESET_CLKS   = 250,
  localparam int LED_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             auto_repeat,
  input  logic             abort,
  output logic [LED_W-1:0] led_sel,
  output logic             load,
  output logic             shift_en,
  output logic             bit_start,
  output logic             latch_active,
  output logic             busy,
  output logic             frame_done
);

  localparam int CLK_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int BIT_W = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
  localparam int LAT_W = (RESET_CLKS > 1) ? $clog2(RESET_CLKS) : 1;

  localparam logic [LED_W-1:0] LED_LAST = LED_W'(N_LEDS - 1);
  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(BIT_CLKS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_LED - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RESET_CLKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [LED_W-1:0]   led_sel_q, led_sel_d;
  logic [CLK_W-1:0]   clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic               abort_flag_q, abort_flag_d;
  logic               load_q, load_d;
  logic               shift_en_q, shift_en_d;
  logic               bit_start_q, bit_start_d;
  logic               latch_active_q, latch_active_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;

  // Next-state and counter update; abort always takes precedence over bit/LED boundaries.
  always_comb begin
    state_d      = state_q;
    led_sel_d    = led_sel_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    abort_flag_d = abort_flag_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          led_sel_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD, ST_SHIFT: begin
        if (abort) begin
          state_d      = ST_LATCH;
          led_sel_d    = '0;
          clk_cnt_d    = '0;
          bit_cnt_d    = '0;
          lat_cnt_d    = '0;
          abort_flag_d = 1'b1;
        end else if (state_q == ST_LOAD) begin
          state_d   = ST_SHIFT;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end else if (clk_cnt_q != CLK_LAST) begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end else if (bit_cnt_q != BIT_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end else if (led_sel_q != LED_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          led_sel_d = led_sel_q + LED_W'(1);
          state_d   = ST_LOAD;
        end else begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          led_sel_d = '0;
          lat_cnt_d = '0;
          state_d   = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (lat_cnt_q == LAT_LAST) begin
          lat_cnt_d    = '0;
          abort_flag_d = 1'b0;
          state_d      = (auto_repeat && !abort_flag_q) ? ST_LOAD : ST_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      default: begin
        state_d      = ST_IDLE;
        led_sel_d    = '0;
        clk_cnt_d    = '0;
        bit_cnt_d    = '0;
        lat_cnt_d    = '0;
        abort_flag_d = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state they describe.
  always_comb begin
    load_d         = (state_d == ST_LOAD);
    bit_start_d    = (state_d == ST_SHIFT) && (clk_cnt_d == '0);
    shift_en_d     = (state_d == ST_SHIFT) && (clk_cnt_d == CLK_LAST);
    latch_active_d = (state_d == ST_LATCH);
    busy_d         = (state_d != ST_IDLE);
    frame_done_d   = (state_d == ST_LATCH) && (lat_cnt_d == LAT_LAST);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      led_sel_q      <= '0;
      clk_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      lat_cnt_q      <= '0;
      abort_flag_q   <= 1'b0;
      load_q         <= 1'b0;
      shift_en_q     <= 1'b0;
      bit_start_q    <= 1'b0;
      latch_active_q <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      led_sel_q      <= led_sel_d;
      clk_cnt_q      <= clk_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      lat_cnt_q      <= lat_cnt_d;
      abort_flag_q   <= abort_flag_d;
      load_q         <= load_d;
      shift_en_q     <= shift_en_d;
      bit_start_q    <= bit_start_d;
      latch_active_q <= latch_active_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign led_sel      = led_sel_q;
  assign load         = load_q;
  assign shift_en     = shift_en_q;
  assign bit_start    = bit_start_q;
  assign latch_active = latch_active_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Self-checking bench for led_frame_sequencer: a position-in-frame arithmetic model checked every cycle,
// plus directed timing pins and a frame-length check of a default-parameter instance.
module tb_led_frame_sequencer;

  localparam int N   = 2;
  localparam int B   = 24;
  localparam int C   = 4;
  localparam int R   = 5;
  localparam int SEG = 1 + B * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, auto_repeat = 1'b0, abort = 1'b0;
  logic [0:0] led_sel;
  logic       load, shift_en, bit_start, latch_active, busy, frame_done;

  logic       d_start = 1'b0, d_auto_repeat = 1'b0, d_abort = 1'b0;
  logic [2:0] d_led_sel;
  logic       d_load, d_shift_en, d_bit_start, d_latch_active, d_busy, d_frame_done;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: mode 0 idle, 1 in LED transmission (m_pos = cycle since first LOAD), 2 in latch gap.
  int m_mode = 0;
  int m_pos  = 0;
  bit m_abf  = 1'b0;

  always #5 clk = ~clk;

  led_frame_sequencer #(.N_LEDS(N), .BITS_PER_LED(B), .BIT_CLKS(C), .RESET_CLKS(R)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .auto_repeat(auto_repeat), .abort(abort),
    .led_sel(led_sel), .load(load), .shift_en(shift_en), .bit_start(bit_start),
    .latch_active(latch_active), .busy(busy), .frame_done(frame_done)
  );

  led_frame_sequencer dut_def (
    .clk(clk), .rst_n(rst_n), .start(d_start), .auto_repeat(d_auto_repeat), .abort(d_abort),
    .led_sel(d_led_sel), .load(d_load), .shift_en(d_shift_en), .bit_start(d_bit_start),
    .latch_active(d_latch_active), .busy(d_busy), .frame_done(d_frame_done)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // {led_sel, load, shift_en, bit_start, latch_active, busy, frame_done}
  function automatic int model_out();
    int v, r, c;
    v = 0;
    if (m_mode == 1) begin
      r = m_pos % SEG;
      v = ((m_pos / SEG) << 6) | 2;
      if (r == 0) v = v | 32;
      else begin
        c = (r - 1) % C;
        if (c == C - 1) v = v | 16;
        if (c == 0)     v = v | 8;
      end
    end else if (m_mode == 2) begin
      v = 4 | 2 | ((m_pos == R - 1) ? 1 : 0);
    end
    return v;
  endfunction

  task automatic model_update(input bit s, input bit ar, input bit ab);
    case (m_mode)
      0: if (s) begin m_mode = 1; m_pos = 0; end
      1: begin
        if (ab) begin m_mode = 2; m_pos = 0; m_abf = 1'b1; end
        else if (m_pos == N * SEG - 1) begin m_mode = 2; m_pos = 0; end
        else m_pos++;
      end
      default: begin
        if (m_pos == R - 1) begin
          m_mode = (ar && !m_abf) ? 1 : 0;
          m_pos  = 0;
          m_abf  = 1'b0;
        end else m_pos++;
      end
    endcase
  endtask

  task automatic step(input bit s, input bit ar, input bit ab);
    start = s; auto_repeat = ar; abort = ab;
    @(posedge clk);
    model_update(s, ar, ab);
    #1;
  endtask

  // Cycle-by-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cycle_outputs",
          int'({led_sel, load, shift_en, bit_start, latch_active, busy, frame_done}), model_out());
    end
  end

  task automatic run_single(input bit ign);
    int rel, nl, nse, nbs, nlat, ld0, ld1, done_at, s0, s1;
    nl = 0; nse = 0; nbs = 0; nlat = 0; ld0 = -1; ld1 = -1; done_at = -1; s0 = -1; s1 = -1;
    step(1'b1, 1'b0, 1'b0);
    rel = 1;
    for (int i = 0; i < 200; i++) begin
      if (load) begin
        if (nl == 0) begin ld0 = rel; s0 = led_sel; end
        else if (nl == 1) begin ld1 = rel; s1 = led_sel; end
        nl++;
      end
      nse += int'(shift_en);
      nbs += int'(bit_start);
      nlat += int'(latch_active);
      if (frame_done) done_at = rel;
      if (rel == 200) chk("single_busy_low_200", busy, 0);
      step(ign && (rel == 50 || rel == 196), 1'b0, ign && rel == 196);
      rel++;
    end
    chk("single_first_load_cycle", ld0, 1);
    chk("single_first_led_sel", s0, 0);
    chk("single_second_load_cycle", ld1, 98);
    chk("single_second_led_sel", s1, 1);
    chk("single_load_count", nl, 2);
    chk("single_shift_en_count", nse, 48);
    chk("single_bit_start_count", nbs, 48);
    chk("single_latch_cycles", nlat, 5);
    chk("single_frame_done_cycle", done_at, 199);
  endtask

  initial begin
    int rel, ndone, nse, nlat, nld, done_at;
    int dt[3];
    bit prev_done, ar_r;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", int'({led_sel, load, shift_en, bit_start, latch_active, busy, frame_done}), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    run_single(1'b0);

    // Auto repeat over three frames.
    step(1'b1, 1'b1, 1'b0);
    rel = 1; ndone = 0; prev_done = 1'b0;
    for (int i = 0; i < 700 && ndone < 3; i++) begin
      if (prev_done) chk("repeat_load_after_done", int'({load, busy, led_sel}), 6);
      prev_done = frame_done;
      if (frame_done) begin dt[ndone] = rel; ndone++; end
      step(1'b0, 1'b1, 1'b0);
      rel++;
    end
    chk("repeat_frame_count", ndone, 3);
    if (ndone == 3) begin
      chk("repeat_spacing_1", dt[1] - dt[0], 199);
      chk("repeat_spacing_2", dt[2] - dt[1], 199);
    end
    chk("repeat_load_after_third_done", int'({load, busy, led_sel}), 6);
    for (int i = 0; i < 250 && busy; i++) step(1'b0, 1'b0, 1'b0);
    chk("repeat_drain_idle", busy, 0);

    // Abort during bit 10 of LED 1 with auto_repeat held high.
    step(1'b1, 1'b1, 1'b0);
    rel = 1;
    while (rel < 140) begin step(1'b0, 1'b1, 1'b0); rel++; end
    step(1'b0, 1'b1, 1'b1);
    nse = 0; nlat = 0; nld = 0; done_at = -1;
    for (int i = 0; i < 10; i++) begin
      nse += int'(shift_en);
      nlat += int'(latch_active);
      nld += int'(load);
      if (frame_done) done_at = i;
      step(1'b0, 1'b1, 1'b0);
    end
    chk("abort_no_shift_en", nse, 0);
    chk("abort_no_load", nld, 0);
    chk("abort_latch_cycles", nlat, 5);
    chk("abort_frame_done_pos", done_at, 4);
    chk("abort_ends_idle", busy, 0);

    // start/abort requests while busy must not change the frame.
    run_single(1'b1);

    // Asynchronous reset mid-SHIFT.
    step(1'b1, 1'b0, 1'b0);
    repeat (60) step(1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    m_mode = 0; m_pos = 0; m_abf = 1'b0;
    #1;
    chk("async_reset_outputs", int'({led_sel, load, shift_en, bit_start, latch_active, busy, frame_done}), 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    run_single(1'b0);

    // Randomized traffic against the model.
    ar_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) ar_r = ~ar_r;
      step($urandom_range(0, 15) == 0, ar_r, $urandom_range(0, 149) == 0);
    end
    for (int i = 0; i < 300 && busy; i++) step(1'b0, 1'b0, 1'b0);
    chk("random_drain_idle", busy, 0);

    // Default-parameter frame length.
    d_start = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    d_start = 1'b0;
    rel = 1; nse = 0; done_at = -1;
    for (int i = 0; i < 13000; i++) begin
      nse += int'(d_shift_en);
      if (d_frame_done) begin done_at = rel; break; end
      step(1'b0, 1'b0, 1'b0);
      rel++;
    end
    chk("default_frame_length", done_at, 12354);
    chk("default_shift_en_count", nse, 192);
    step(1'b0, 1'b0, 1'b0);
    chk("default_busy_low_after", d_busy, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
